// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared types and constants for the RISC sequencing controller.
//   - state_e        : controller states
//   - instr_class_e  : instruction class latched in DECODE
//   - opcode/op field constants, nsel/vsel codes
//   - ctrl_out_t     : bundle of every controller output
//   - state_outputs(): Moore output decode (state + latched class only)
package cpu_ctrl_pkg;

  localparam int NUM_STATES = 8;

  typedef enum logic [2:0] {
    ST_WAIT      = 3'd0,
    ST_DECODE    = 3'd1,
    ST_WRITE_IMM = 3'd2,
    ST_GET_A     = 3'd3,
    ST_GET_B     = 3'd4,
    ST_EXEC      = 3'd5,
    ST_WRITE_REG = 3'd6,
    ST_HALT      = 3'd7
  } state_e;

  typedef enum logic [2:0] {
    CLS_MOVI = 3'd0,  // MOV Rn,#imm8
    CLS_MOVR = 3'd1,  // MOV Rd,Rm{,sh}
    CLS_ALU2 = 3'd2,  // ADD / AND: two sources, result written
    CLS_CMP  = 3'd3,  // CMP: status only
    CLS_MVN  = 3'd4,  // MVN Rd,Rm{,sh}
    CLS_HALT = 3'd5,
    CLS_ILL  = 3'd6
  } instr_class_e;

  // opcode field [15:13]
  localparam logic [2:0] OPC_MOV  = 3'b110;
  localparam logic [2:0] OPC_ALU  = 3'b101;
  localparam logic [2:0] OPC_HALT = 3'b111;

  // op field [12:11]
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  // regfile index select (one-hot)
  localparam logic [2:0] NSEL_NONE = 3'b000;
  localparam logic [2:0] NSEL_RN   = 3'b001;
  localparam logic [2:0] NSEL_RD   = 3'b010;
  localparam logic [2:0] NSEL_RM   = 3'b100;

  // regfile write-data source
  localparam logic [1:0] VSEL_C   = 2'b00;
  localparam logic [1:0] VSEL_IMM = 2'b10;

  typedef struct packed {
    logic       w;
    logic [2:0] nsel;
    logic [1:0] vsel;
    logic       write;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic       bsel;
    logic       halted;
  } ctrl_out_t;

  // Every output not set here stays 0, which is what keeps write and the
  // load enables mutually exclusive and nsel one-hot or zero.
  function automatic ctrl_out_t state_outputs(state_e st, instr_class_e cls);
    ctrl_out_t o;
    o = '0;
    case (st)
      ST_WAIT: o.w = 1'b1;
      ST_WRITE_IMM: begin
        o.nsel  = NSEL_RN;
        o.vsel  = VSEL_IMM;
        o.write = 1'b1;
      end
      ST_GET_A: begin
        o.nsel  = NSEL_RN;
        o.loada = 1'b1;
      end
      ST_GET_B: begin
        o.nsel  = NSEL_RM;
        o.loadb = 1'b1;
      end
      ST_EXEC: begin
        o.loadc = 1'b1;
        // Single-operand moves pass B through an ALU add with A forced to 0.
        o.asel  = (cls == CLS_MOVR) || (cls == CLS_MVN);
        o.loads = (cls == CLS_CMP);
      end
      ST_WRITE_REG: begin
        o.nsel  = NSEL_RD;
        o.vsel  = VSEL_C;
        o.write = 1'b1;
      end
      ST_HALT: o.halted = 1'b1;
      default: o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/cpu_controller_if.sv
// cpu_controller_if: handshake/control bundle between the controller and
// the CPU top level.
//   master : the controller (reads s/opcode/op, drives everything else)
//   slave  : the top level / datapath side
// Signals: s, opcode[2:0], op[1:0] -> controller
//          w, nsel[2:0], vsel[1:0], write, loada, loadb, loadc, loads,
//          asel, bsel, halted     <- controller
interface cpu_controller_if;
  logic       s;
  logic [2:0] opcode;
  logic [1:0] op;
  logic       w;
  logic [2:0] nsel;
  logic [1:0] vsel;
  logic       write;
  logic       loada;
  logic       loadb;
  logic       loadc;
  logic       loads;
  logic       asel;
  logic       bsel;
  logic       halted;

  modport master (
    input  s, opcode, op,
    output w, nsel, vsel, write, loada, loadb, loadc, loads, asel, bsel, halted
  );

  modport slave (
    output s, opcode, op,
    input  w, nsel, vsel, write, loada, loadb, loadc, loads, asel, bsel, halted
  );
endinterface

// File: rtl/cpu_ctrl_decode.sv
// cpu_ctrl_decode: combinational map from instruction fields to class.
//   opcode_i[2:0] : instruction bits [15:13]
//   op_i[1:0]     : instruction bits [12:11]
//   cls_o         : instruction class; CLS_ILL for anything unsupported
// Opcode 111 decodes to CLS_HALT only when CPU_CTRL_HALT_EN is defined.
module cpu_ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [2:0]   opcode_i,
  input  logic [1:0]   op_i,
  output instr_class_e cls_o
);

  always_comb begin
    cls_o = CLS_ILL;
    case (opcode_i)
      OPC_MOV: begin
        case (op_i)
          OP_MOV_IMM: cls_o = CLS_MOVI;
          OP_MOV_REG: cls_o = CLS_MOVR;
          default:    cls_o = CLS_ILL;
        endcase
      end
      OPC_ALU: begin
        case (op_i)
          OP_ADD:  cls_o = CLS_ALU2;
          OP_AND:  cls_o = CLS_ALU2;
          OP_CMP:  cls_o = CLS_CMP;
          OP_MVN:  cls_o = CLS_MVN;
          default: cls_o = CLS_ILL;
        endcase
      end
`ifdef CPU_CTRL_HALT_EN
      OPC_HALT: cls_o = CLS_HALT;
`endif
      default: cls_o = CLS_ILL;
    endcase
  end

endmodule

// File: rtl/cpu_controller.sv
// cpu_controller: Moore FSM sequencing the register file and datapath of the
// simple RISC machine, one multi-cycle instruction per start pulse.
//   clk    : rising-edge clock
//   reset  : synchronous active-high reset -> WAIT, w=1, all strobes 0
//   bus    : cpu_controller_if.master (s/opcode/op in; w, nsel, vsel, write,
//            loada/b/c, loads, asel, bsel, halted out)
// Parameter STATE_ONEHOT selects binary (0) or one-hot (1) state storage;
// port behaviour is identical either way.
// Optional feature macro: CPU_CTRL_HALT_EN (opcode 111 enters a sticky HALT
// state left only by reset). Without it 111 is illegal and halted is 0.
module cpu_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int STATE_ONEHOT = 0
) (
  input logic              clk,
  input logic              reset,
  cpu_controller_if.master bus
);

  localparam int SW = (STATE_ONEHOT != 0) ? NUM_STATES : 3;

  logic [SW-1:0] state_q, state_d;
  instr_class_e  cls_q, cls_d;
  ctrl_out_t     out_q, out_d;
  instr_class_e  dec_cls;
  state_e        cur_state, nxt_state;

  function automatic logic [SW-1:0] enc_state(state_e st);
    logic [NUM_STATES-1:0] oh;
    oh     = '0;
    oh[st] = 1'b1;
    if (STATE_ONEHOT != 0) return SW'(oh);
    else                   return SW'(st);
  endfunction

  // An all-zero one-hot vector (only reachable by upset) falls back to WAIT.
  function automatic state_e dec_state(logic [SW-1:0] code);
    state_e st;
    st = ST_WAIT;
    if (STATE_ONEHOT != 0) begin
      for (int i = 0; i < SW; i++) begin
        if (code[i]) st = state_e'(i[2:0]);
      end
    end else begin
      st = state_e'(code[2:0]);
    end
    return st;
  endfunction

  cpu_ctrl_decode u_decode (
    .opcode_i (bus.opcode),
    .op_i     (bus.op),
    .cls_o    (dec_cls)
  );

  always_comb begin
    cur_state = dec_state(state_q);
    nxt_state = cur_state;
    cls_d     = cls_q;
    case (cur_state)
      ST_WAIT: if (bus.s) nxt_state = ST_DECODE;
      ST_DECODE: begin
        // The class is latched here so later states never look at the
        // instruction fields again.
        cls_d = dec_cls;
        case (dec_cls)
          CLS_MOVI:          nxt_state = ST_WRITE_IMM;
          CLS_MOVR, CLS_MVN: nxt_state = ST_GET_B;
          CLS_ALU2, CLS_CMP: nxt_state = ST_GET_A;
`ifdef CPU_CTRL_HALT_EN
          CLS_HALT:          nxt_state = ST_HALT;
`endif
          default:           nxt_state = ST_WAIT;
        endcase
      end
      ST_WRITE_IMM: nxt_state = ST_WAIT;
      ST_GET_A:     nxt_state = ST_GET_B;
      ST_GET_B:     nxt_state = ST_EXEC;
      ST_EXEC:      nxt_state = (cls_q == CLS_CMP) ? ST_WAIT : ST_WRITE_REG;
      ST_WRITE_REG: nxt_state = ST_WAIT;
`ifdef CPU_CTRL_HALT_EN
      ST_HALT:      nxt_state = ST_HALT;
`else
      ST_HALT:      nxt_state = ST_WAIT;
`endif
      default:      nxt_state = ST_WAIT;
    endcase

    state_d = enc_state(nxt_state);
    // Outputs are registered alongside the state, so they are a pure
    // function of the state the machine is about to enter.
    out_d   = state_outputs(nxt_state, cls_d);
`ifndef CPU_CTRL_HALT_EN
    out_d.halted = 1'b0;
`endif
  end

  // Reset drops any pending write: WAIT outputs are loaded directly.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= enc_state(ST_WAIT);
      cls_q   <= CLS_ILL;
      out_q   <= state_outputs(ST_WAIT, CLS_ILL);
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      out_q   <= out_d;
    end
  end

  assign bus.w      = out_q.w;
  assign bus.nsel   = out_q.nsel;
  assign bus.vsel   = out_q.vsel;
  assign bus.write  = out_q.write;
  assign bus.loada  = out_q.loada;
  assign bus.loadb  = out_q.loadb;
  assign bus.loadc  = out_q.loadc;
  assign bus.loads  = out_q.loads;
  assign bus.asel   = out_q.asel;
  assign bus.bsel   = out_q.bsel;
  assign bus.halted = out_q.halted;

endmodule
